// File: rtl/snake_pkg.sv
// snake_pkg
// Shared definitions for the Snake score path: FSM state encoding, score
// width and the default saturation ceiling.
// No ports (package).
package snake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam int SCORE_W       = 16;
  localparam int MAX_SCORE_DEF = 9999;

endpackage

// File: rtl/rise_detect.sv
// rise_detect
// Single-cycle rising-edge detector for a level that is already synchronous
// to clk. A level held high produces exactly one pulse.
// Ports:
//   clk     - system clock
//   rst     - asynchronous active-high reset, clears the history register
//   i_level - level input
//   o_rise  - high for the cycle in which i_level is high and was low before
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_rise
);

  logic r_levelQ;

  // One-cycle history of the level, used to spot the low-to-high transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_levelQ <= 1'b0;
    end else begin
      r_levelQ <= i_level;
    end
  end

  assign o_rise = i_level & ~r_levelQ;

endmodule

// File: rtl/score_keeper.sv
// score_keeper
// Turns Snake game events into a saturating score and a persistent high
// score, and feeds the 4-digit seven-segment driver (num / enable).
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset
//   start      - level; rising edge starts or restarts a game
//   eat        - level; each rising edge is one food event
//   game_over  - level; high while the game has ended
//   show_high  - level; while high, num shows the high score
//   num        - registered binary value for the display (<= MAX_SCORE)
//   enable     - registered display enable, blinks after game over
//   new_record - registered; set by the game that beat the high score
module score_keeper
  import snake_pkg::*;
#(
  parameter int POINTS_PER_FOOD = 1,
  parameter int MAX_SCORE       = MAX_SCORE_DEF,
  parameter int BLINK_DIV       = 25000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               eat,
  input  logic               game_over,
  input  logic               show_high,
  output logic [SCORE_W-1:0] num,
  output logic               enable,
  output logic               new_record
);

  localparam int CNT_W = $clog2(BLINK_DIV);

  state_t             r_state;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] r_high;
  logic [SCORE_W-1:0] r_num;
  logic [CNT_W-1:0]   r_blinkCnt;
  logic               r_enable;
  logic               r_newRecord;

  logic               w_startRise;
  logic               w_eatRise;
  logic [SCORE_W:0]   w_sum;
  logic [SCORE_W-1:0] w_clamped;
  logic [SCORE_W-1:0] w_nextScore;

  rise_detect u_startRise (
    .clk     (clk),
    .rst     (rst),
    .i_level (start),
    .o_rise  (w_startRise)
  );

  rise_detect u_eatRise (
    .clk     (clk),
    .rst     (rst),
    .i_level (eat),
    .o_rise  (w_eatRise)
  );

  // The add is one bit wider than the score so a sum past the ceiling can
  // never wrap before it is clamped.
  assign w_sum       = {1'b0, r_score} + (SCORE_W+1)'(POINTS_PER_FOOD);
  assign w_clamped   = (w_sum > (SCORE_W+1)'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE)
                                                          : w_sum[SCORE_W-1:0];
  // Score as it will be after this edge, so a food event landing in the same
  // cycle as game over still counts toward the high score comparison.
  assign w_nextScore = w_eatRise ? w_clamped : r_score;

  // Game FSM with the blink counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_score     <= '0;
      r_high      <= '0;
      r_blinkCnt  <= '0;
      r_enable    <= 1'b1;
      r_newRecord <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_enable <= 1'b1;
          if (w_startRise) begin
            r_state     <= ST_PLAY;
            r_score     <= '0;
            r_newRecord <= 1'b0;
          end
        end
        ST_PLAY: begin
          r_enable <= 1'b1;
          r_score  <= w_nextScore;
          // game_over wins over start; start is simply not looked at here.
          if (game_over) begin
            r_state    <= ST_OVER;
            r_blinkCnt <= '0;
            r_enable   <= 1'b0;
            if (w_nextScore > r_high) begin
              r_high      <= w_nextScore;
              r_newRecord <= 1'b1;
            end
          end
        end
        ST_OVER: begin
          if (w_startRise) begin
            r_state     <= ST_PLAY;
            r_score     <= '0;
            r_newRecord <= 1'b0;
            r_enable    <= 1'b1;
            r_blinkCnt  <= '0;
          end else if (r_blinkCnt == CNT_W'(BLINK_DIV - 1)) begin
            r_blinkCnt <= '0;
            r_enable   <= ~r_enable;
          end else begin
            r_blinkCnt <= r_blinkCnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Registered display mux; it follows the score register one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_num <= '0;
    end else begin
      r_num <= (show_high || (r_state == ST_IDLE)) ? r_high : r_score;
    end
  end

  assign num        = r_num;
  assign enable     = r_enable;
  assign new_record = r_newRecord;

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper
// Directed bench for score_keeper. Two instances share all stimulus: the
// main one with default scoring, and one with MAX_SCORE=10 and
// POINTS_PER_FOOD=3 to exercise saturation. Both blink with BLINK_DIV=4.
module tb_score_keeper;

  logic        clk;
  logic        rst;
  logic        start;
  logic        eat;
  logic        game_over;
  logic        show_high;
  logic [15:0] num;
  logic        enable;
  logic        new_record;
  logic [15:0] numSat;
  logic        enableSat;
  logic        newRecordSat;

  int checkCount;
  int failCount;

  score_keeper #(
    .POINTS_PER_FOOD (1),
    .MAX_SCORE       (9999),
    .BLINK_DIV       (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .eat        (eat),
    .game_over  (game_over),
    .show_high  (show_high),
    .num        (num),
    .enable     (enable),
    .new_record (new_record)
  );

  score_keeper #(
    .POINTS_PER_FOOD (3),
    .MAX_SCORE       (10),
    .BLINK_DIV       (4)
  ) dutSat (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .eat        (eat),
    .game_over  (game_over),
    .show_high  (show_high),
    .num        (numSat),
    .enable     (enableSat),
    .new_record (newRecordSat)
  );

  // 100 MHz-style free running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One food pulse: num must hold on the sampling edge and update one edge
  // later. A negative expSat skips the saturating instance.
  task automatic eatPulse(input int prevMain, input int expMain, input int expSat);
    eat = 1'b1;
    tick();
    checkOutput("num_lag", int'(num), prevMain);
    eat = 1'b0;
    tick();
    checkOutput("num_after_eat", int'(num), expMain);
    if (expSat >= 0) begin
      checkOutput("num_sat", int'(numSat), expSat);
    end
  endtask

  task automatic applyStimulus();
    // Reset
    rst = 1'b1; start = 1'b0; eat = 1'b0; game_over = 1'b0; show_high = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checkOutput("reset_num", int'(num), 0);
    checkOutput("reset_enable", int'(enable), 1);
    checkOutput("reset_new_record", int'(new_record), 0);

    // Basic scoring
    start = 1'b1; tick(); start = 1'b0; tick();
    eatPulse(0, 1, 3);
    eatPulse(1, 2, 6);
    eatPulse(2, 3, 9);
    eat = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    eat = 1'b0;
    checkOutput("held_eat_num", int'(num), 4);
    checkOutput("held_eat_sat", int'(numSat), 10);
    tick();
    checkOutput("held_eat_num_stable", int'(num), 4);

    // Saturation on a fresh game
    rst = 1'b1; tick(); rst = 1'b0; tick();
    start = 1'b1; tick(); start = 1'b0; tick();
    eatPulse(0, 1, 3);
    eatPulse(1, 2, 6);
    eatPulse(2, 3, 9);
    eatPulse(3, 4, 10);
    eatPulse(4, 5, 10);

    // Game over with a new record, then the blink pattern
    eatPulse(5, 6, 10);
    eatPulse(6, 7, 10);
    game_over = 1'b1;
    tick();
    checkOutput("go_new_record", int'(new_record), 1);
    checkOutput("go_sat_new_record", int'(newRecordSat), 1);
    checkOutput("go_blink_0", int'(enable), 0);
    for (int k = 1; k < 12; k++) begin
      tick();
      checkOutput("go_blink", int'(enable), ((k / 4) % 2));
    end

    // Restart while game_over is still high, then lose at score 5
    start = 1'b1;
    tick();
    checkOutput("restart_new_record", int'(new_record), 0);
    checkOutput("restart_enable", int'(enable), 1);
    start = 1'b0; game_over = 1'b0;
    tick();
    checkOutput("restart_num", int'(num), 0);
    eatPulse(0, 1, 3);
    eatPulse(1, 2, 6);
    eatPulse(2, 3, 9);
    eatPulse(3, 4, 10);
    eatPulse(4, 5, 10);
    game_over = 1'b1;
    tick();
    checkOutput("no_record", int'(new_record), 0);
    checkOutput("no_record_sat", int'(newRecordSat), 0);
    show_high = 1'b1; tick();
    checkOutput("high_kept", int'(num), 7);
    show_high = 1'b0; tick();
    checkOutput("score_after_high", int'(num), 5);

    // Eat rise and game over in the same cycle at score 7 / high 7
    start = 1'b1; game_over = 1'b0; tick();
    start = 1'b0; tick();
    for (int s = 0; s < 7; s++) eatPulse(s, s + 1, -1);
    eat = 1'b1; game_over = 1'b1;
    tick();
    checkOutput("simul_new_record", int'(new_record), 1);
    eat = 1'b0;
    tick();
    checkOutput("simul_score", int'(num), 8);
    show_high = 1'b1; tick();
    checkOutput("simul_high", int'(num), 8);
    show_high = 1'b0;

    // start and game_over together while playing
    start = 1'b1; tick();
    start = 1'b0; game_over = 1'b0; tick();
    checkOutput("replay_enable", int'(enable), 1);
    start = 1'b1; game_over = 1'b1;
    tick();
    checkOutput("start_go_enable", int'(enable), 0);
    start = 1'b0;
    tick();
    checkOutput("start_go_enable_hold", int'(enable), 0);

    // show_high while playing
    start = 1'b1; game_over = 1'b0; tick();
    start = 1'b0; tick();
    eatPulse(0, 1, -1);
    eatPulse(1, 2, -1);
    show_high = 1'b1; tick();
    checkOutput("show_high_num", int'(num), 8);
    show_high = 1'b0; tick();
    checkOutput("show_high_release", int'(num), 2);
    checkOutput("play_enable", int'(enable), 1);

    // New record again, then an asynchronous reset mid-blink
    for (int s = 2; s < 9; s++) eatPulse(s, s + 1, -1);
    game_over = 1'b1;
    tick();
    checkOutput("second_record", int'(new_record), 1);
    tick();
    checkOutput("second_record_num", int'(num), 9);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_num", int'(num), 0);
    checkOutput("async_rst_enable", int'(enable), 1);
    checkOutput("async_rst_new_record", int'(new_record), 0);
    tick();
    rst = 1'b0; game_over = 1'b0;
    tick();
    show_high = 1'b1; tick();
    checkOutput("rst_clears_high", int'(num), 0);
    show_high = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    applyStimulus();
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Sequential stage directly upstream of the 4-digit seven-segment display driver in the Snake design.
- Turns game events (food eaten, game over, start) into a saturating binary score and a persistent high score.
- Drives the driver's 16-bit binary `num` input and its `enable` input, and blinks the display after game over.

Parameters:
- POINTS_PER_FOOD, 1, amount added per food event (1..MAX_SCORE).
- MAX_SCORE, 9999, saturation ceiling; keeps the value displayable on 4 decimal digits.
- BLINK_DIV, 25000000, clock cycles per enable toggle in OVER (0.25 s at 100 MHz); must be >= 2.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  level, synchronous to clk; rising edge starts or restarts a game.
- eat  input  1  level, synchronous to clk; each rising edge is one food event.
- game_over  input  1  level, synchronous to clk; high while the game has ended.
- show_high  input  1  level; while high, num shows the high score instead of the current score.
- num  output  16  registered binary value for the display driver, always <= MAX_SCORE.
- enable  output  1  registered display enable for the display driver.
- new_record  output  1  registered; high from the game that set a new high score until the next start.

Behaviour:
- Reset (async, on rst high): state=IDLE, score=0, high=0, blink_cnt=0, num=0, enable=1, new_record=0, edge-detect history regs=0.
- Edge detection: start and eat each have a 1-cycle history register.
  - rise = in & ~in_q.
  - A level held high counts once.
- States: IDLE, PLAY, OVER (2-bit encoding).
- IDLE:
  - score held.
  - num source = high.
  - enable=1.
  - start_rise -> PLAY; score<=0; new_record<=0.
- PLAY:
  - eat_rise -> score <= min(score + POINTS_PER_FOOD, MAX_SCORE). Add in 17 bits, then clamp.
  - game_over=1 -> OVER. On that edge: if next_score > high then high<=next_score and new_record<=1. next_score includes an eat_rise in the same cycle.
  - start_rise is ignored in PLAY.
  - game_over takes priority over start in the same cycle.
- OVER:
  - eat ignored.
  - blink_cnt counts 0..BLINK_DIV-1. At terminal count it wraps to 0 and enable toggles.
  - Entering OVER sets blink_cnt=0 and enable=0.
  - start_rise -> PLAY: score<=0, new_record<=0, enable<=1, blink_cnt<=0. This applies even if game_over is still high.
- Output mux:
  - num <= (show_high | state==IDLE) ? high : score.
  - The mux output is registered. num reflects a score change 1 cycle after the score register updates, i.e. on the 2nd rising edge after eat is first sampled high.
- enable in IDLE and PLAY is constant 1.
- Saturation: score never exceeds MAX_SCORE; eat events at MAX_SCORE leave it unchanged.
- The high score survives restarts and is cleared only by rst.
- rst mid-game aborts immediately to the reset state. There is no partial update of high.

Decomposition:
- Shared package snake_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_PLAY=2'd1, ST_OVER=2'd2;
  - SCORE_W=16;
  - the default MAX_SCORE constant.
- One sub-module: rise_detect. It takes clk, rst and a level input, and produces a 1-cycle pulse. It is instantiated twice, for start and eat.
- The blink counter and FSM stay inline.

Test Plan (all scenarios use BLINK_DIV=4):
- Reset: assert rst mid-run -> num=0, enable=1, new_record=0 immediately (async), state IDLE.
- Basic scoring: start pulse, 3 separate eat pulses, one eat held 10 cycles -> num=4; num changes 2 edges after each eat sample.
- Saturation: MAX_SCORE=10, POINTS_PER_FOOD=3, 5 eat pulses -> num sequence 3,6,9,10,10.
- Game over and record:
  - Score 7, high 0, game_over=1 -> high=7, new_record=1, enable low 4 cycles, high 4, repeating.
  - Restart then game over at score 5 -> high stays 7, new_record=0.
- Simultaneous events:
  - eat rise and game_over in the same cycle at score 7 with high 7 -> score=8, high=8, new_record=1.
  - start and game_over together in PLAY -> goes to OVER.
- show_high: in PLAY with score 2, high 8, hold show_high -> num=8. Release -> num=2 on the next edge. In IDLE -> num=high regardless.
